// File: rtl/q_8_38_pkg.sv
// Shared types and constants for the sign-magnitude adder.
// sm_t is sized from DEFAULT_WIDTH, so the top-level WIDTH must match it.
package q_8_38_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int MAG_WIDTH     = DEFAULT_WIDTH - 1;

   typedef struct packed {
      logic                 sign;
      logic [MAG_WIDTH-1:0] mag;
   } sm_t;

   localparam sm_t SM_POS_ZERO = '{sign: 1'b0, mag: '0};
   localparam sm_t SM_NEG_ZERO = '{sign: 1'b1, mag: '0};

   // Largest representable magnitude with the given sign
   function automatic sm_t sm_saturate(input logic sign);
      sm_t r;
      r.sign = sign;
      r.mag  = '1;
      return r;
   endfunction

endpackage

// File: rtl/q_8_38_mag_unit.sv
// Combinational sign-magnitude add/subtract core.
// Same signs add magnitudes (carry = magnitude overflow, wrapped result).
// Different signs subtract the smaller magnitude from the larger and take
// the larger operand's sign; equal magnitudes give positive zero.
module q_8_38_mag_unit
   import q_8_38_pkg::*;
(
   input  logic                 sign_a,
   input  logic                 sign_b,
   input  logic [MAG_WIDTH-1:0] mag_a,
   input  logic [MAG_WIDTH-1:0] mag_b,
   output sm_t                  result,
   output logic                 carry
);

   logic [MAG_WIDTH:0]   mag_sum;
   logic [MAG_WIDTH-1:0] diff_ab;
   logic [MAG_WIDTH-1:0] diff_ba;

   assign mag_sum = {1'b0, mag_a} + {1'b0, mag_b};
   assign diff_ab = mag_a - mag_b;
   assign diff_ba = mag_b - mag_a;

   // Pick the add path or the compare/subtract path and select the sign
   always_comb begin
      result = SM_POS_ZERO;
      carry  = 1'b0;
      if (sign_a == sign_b) begin
         result.sign = sign_a;
         result.mag  = mag_sum[MAG_WIDTH-1:0];
         carry       = mag_sum[MAG_WIDTH];
      end else if (mag_a > mag_b) begin
         result.sign = sign_a;
         result.mag  = diff_ab;
      end else if (mag_b > mag_a) begin
         result.sign = sign_b;
         result.mag  = diff_ba;
      end
   end

endmodule

// File: rtl/q_8_38_signed_add.sv
// Registered sign-magnitude adder, one cycle of latency.
// Optional build macro: Q838_SAT_EN -- when defined, a same-sign overflow
// saturates the magnitude to all ones instead of wrapping (carry still set).
module q_8_38_signed_add
   import q_8_38_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   sm_t  mag_result;
   logic mag_carry;
   sm_t  next_sum;

   q_8_38_mag_unit u_mag_unit (
      .sign_a (A[WIDTH-1]),
      .sign_b (B[WIDTH-1]),
      .mag_a  (A[WIDTH-2:0]),
      .mag_b  (B[WIDTH-2:0]),
      .result (mag_result),
      .carry  (mag_carry)
   );

`ifdef Q838_SAT_EN
   // Clamp the magnitude on a same-sign overflow; carry only occurs there
   always_comb begin
      next_sum = mag_result;
      if (mag_carry) begin
         next_sum = sm_saturate(mag_result.sign);
      end
   end
`else
   // Wrap-around build passes the core result straight through
   always_comb begin
      next_sum = mag_result;
   end
`endif

   // Output stage: valid follows in_valid, result only loads on valid input
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         sum       <= SM_POS_ZERO;
         carry     <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum   <= next_sum;
            carry <= mag_carry;
         end
      end
   end

endmodule

// File: tb/tb_q_8_38_signed_add.sv
// Self-checking bench for q_8_38_signed_add.
// Honours Q838_SAT_EN so the same bench covers both builds.
module tb_q_8_38_signed_add;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [7:0] A;
   logic [7:0] B;
   logic       out_valid;
   logic [7:0] sum;
   logic       carry;

   int errors = 0;
   int checks = 0;

   q_8_38_signed_add #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .sum       (sum),
      .carry     (carry)
   );

   // 10-unit clock period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: treat operands as signed integers and re-encode the total
   function automatic logic [8:0] model_f(input logic [7:0] a, input logic [7:0] b);
      int         ma, mb, va, vb, total;
      logic [7:0] s;
      logic       c;
      ma = int'(a[6:0]);
      mb = int'(b[6:0]);
      if (a[7] == b[7]) begin
         total = ma + mb;
         c     = (total > 127);
`ifdef Q838_SAT_EN
         if (c) s = {a[7], 7'h7F};
         else   s = {a[7], 7'(total)};
`else
         s = {a[7], 7'(total % 128)};
`endif
      end else begin
         va    = a[7] ? -ma : ma;
         vb    = b[7] ? -mb : mb;
         total = va + vb;
         c     = 1'b0;
         if (total > 0)      s = {1'b0, 7'(total)};
         else if (total < 0) s = {1'b1, 7'(-total)};
         else                s = 8'h00;
      end
      return {c, s};
   endfunction

   task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      in_valid = v;
      A        = a;
      B        = b;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [8:0] exp;
      // Reset state
      checks++;
      if ({out_valid, carry, sum} !== 10'b0) begin
         errors++;
         $display("[TB] FAIL reset_state: got valid=%b carry=%b sum=%h, want 0/0/00", out_valid, carry, sum);
      end
      @(negedge clk);
      rst = 1'b0;
      // Get a nonzero result in flight, then hit reset mid-cycle
      drive(1'b1, 8'h05, 8'h03);
      checks++;
      if (out_valid !== 1'b1 || sum !== 8'h08) begin
         errors++;
         $display("[TB] FAIL pre_reset: got valid=%b sum=%h, want 1/08", out_valid, sum);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, carry, sum} !== 10'b0) begin
         errors++;
         $display("[TB] FAIL async_reset: got valid=%b carry=%b sum=%h, want 0/0/00", out_valid, carry, sum);
      end
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL post_reset_idle: got valid=%b, want 0", out_valid);
      end
      drive(1'b1, 8'h40, 8'h40);
      exp = model_f(8'h40, 8'h40);
      checks++;
      if (out_valid !== 1'b1 || {carry, sum} !== exp) begin
         errors++;
         $display("[TB] FAIL first_after_reset: got valid=%b carry=%b sum=%h, want 1/%b/%h", out_valid, carry, sum, exp[8], exp[7:0]);
      end
   endtask

   task automatic test_directed();
      logic [7:0] ta [10] = '{8'h05, 8'h85, 8'h85, 8'h05, 8'h83, 8'h80, 8'h40, 8'hFF, 8'h80, 8'h80};
      logic [7:0] tb [10] = '{8'h03, 8'h83, 8'h03, 8'h83, 8'h03, 8'h80, 8'h40, 8'hFF, 8'h05, 8'h85};
`ifdef Q838_SAT_EN
      logic [7:0] ts [10] = '{8'h08, 8'h88, 8'h82, 8'h02, 8'h00, 8'h80, 8'h7F, 8'hFF, 8'h05, 8'h85};
`else
      logic [7:0] ts [10] = '{8'h08, 8'h88, 8'h82, 8'h02, 8'h00, 8'h80, 8'h00, 8'hFE, 8'h05, 8'h85};
`endif
      logic       tc [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, ta[i], tb[i]);
         checks++;
         if (out_valid !== 1'b1 || sum !== ts[i] || carry !== tc[i]) begin
            errors++;
            $display("[TB] FAIL directed_%0d: A=%h B=%h got valid=%b sum=%h carry=%b, want 1/%h/%b", i, ta[i], tb[i], out_valid, sum, carry, ts[i], tc[i]);
         end
      end
   endtask

   task automatic test_hold();
      logic [8:0] exp;
      drive(1'b1, 8'hC0, 8'hC1);
      exp = model_f(8'hC0, 8'hC1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 8'($urandom), 8'($urandom));
         checks++;
         if (out_valid !== 1'b0 || {carry, sum} !== exp) begin
            errors++;
            $display("[TB] FAIL hold_%0d: got valid=%b carry=%b sum=%h, want 0/%b/%h", i, out_valid, carry, sum, exp[8], exp[7:0]);
         end
      end
   endtask

   task automatic test_random();
      logic [8:0] held;
      logic [7:0] a, b;
      logic       v;
      drive(1'b1, 8'h00, 8'h00);
      held = model_f(8'h00, 8'h00);
      for (int i = 0; i < 2000; i++) begin
         v = 1'($urandom);
         a = 8'($urandom);
         b = 8'($urandom);
         drive(v, a, b);
         if (v) held = model_f(a, b);
         checks++;
         if (out_valid !== v || {carry, sum} !== held) begin
            errors++;
            $display("[TB] FAIL random_%0d: A=%h B=%h v=%b got valid=%b carry=%b sum=%h, want %b/%b/%h", i, a, b, v, out_valid, carry, sum, v, held[8], held[7:0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] exp;
      logic [7:0] a, b;
      for (int i = 0; i < 65536; i++) begin
         a = 8'(i >> 8);
         b = 8'(i);
         drive(1'b1, a, b);
         exp = model_f(a, b);
         checks++;
         if (out_valid !== 1'b1 || {carry, sum} !== exp) begin
            errors++;
            $display("[TB] FAIL exhaustive: A=%h B=%h got valid=%b carry=%b sum=%h, want 1/%b/%h", a, b, out_valid, carry, sum, exp[8], exp[7:0]);
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      A        = 8'h00;
      B        = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_directed();
      test_hold();
      test_random();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
